// File: rtl/mux_7segmt_scan.sv
// N-digit multiplexed 7-segment scanner with per-slot blanking, double-buffered patterns and digit enables.
// Optional macro MUX7SEG_DIM_EN adds a 4-bit brightness input that PWM-gates the DRIVE phase.
module mux_7segmt_scan #(
    parameter int unsigned N_DIGITS         = 4,
    parameter int unsigned REFRESH_DIV      = 100000,
    parameter int unsigned BLANK_CYCLES     = 16,
    parameter int unsigned ANODE_ACTIVE_LOW = 1,
    localparam int unsigned IDX_W           = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                    Clk_signal,
    input  logic                    Reset,
    input  logic [7*N_DIGITS-1:0]   disp_flat,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     digit_en,
`ifdef MUX7SEG_DIM_EN
    input  logic [3:0]              brightness,
`endif
    output logic [N_DIGITS-1:0]     anodes,
    output logic [6:0]              segments,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_start
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [N_DIGITS-1:0] ANODES_OFF = (ANODE_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {BLANK, DRIVE} state_t;

    // cnt_q/idx_q/state_q describe the slot position the outputs will present after the next edge
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                boundary_q;
    logic                last_c;
    logic                drive_c;
    logic                frame_start_c;
    logic [N_DIGITS-1:0] onehot_c;
    logic [N_DIGITS-1:0] anodes_c;
    logic [6:0]          segments_c;

    logic [7*N_DIGITS-1:0] staging_q;
    logic                  pending_q;
    logic [6:0]            shadow_q [N_DIGITS];

`ifdef MUX7SEG_DIM_EN
    logic [3:0] duty_q, duty_c;
    logic [3:0] bright_q;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_d       = state_q;
        cnt_d         = CNT_W'(cnt_q + 1'b1);
        idx_d         = idx_q;
        last_c        = 1'b0;
        onehot_c      = '0;
        anodes_c      = ANODES_OFF;
        segments_c    = SEG_OFF;
        frame_start_c = (cnt_q == '0) && (idx_q == '0);

        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d   = '0;
            state_d = BLANK;
            last_c  = (idx_q == IDX_W'(N_DIGITS - 1));
            idx_d   = last_c ? '0 : IDX_W'(idx_q + 1'b1);
        end else if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = DRIVE;
        end

        drive_c = (state_q == DRIVE) && digit_en[idx_q];
`ifdef MUX7SEG_DIM_EN
        duty_c  = (cnt_q == CNT_W'(BLANK_CYCLES)) ? 4'd0 : duty_q;
        drive_c = drive_c && (duty_c < bright_q);
`endif

        if (drive_c) begin
            onehot_c[idx_q] = 1'b1;
            anodes_c        = (ANODE_ACTIVE_LOW != 0) ? ~onehot_c : onehot_c;
            segments_c      = shadow_q[idx_q];
        end
    end

    // Sequencer, output registers and pattern double buffer
    always_ff @(posedge Clk_signal) begin
        if (Reset) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            boundary_q  <= 1'b0;
            anodes      <= ANODES_OFF;
            segments    <= SEG_OFF;
            digit_idx   <= '0;
            frame_start <= 1'b0;
            staging_q   <= {N_DIGITS{SEG_OFF}};
            pending_q   <= 1'b0;
            for (int i = 0; i < int'(N_DIGITS); i++) shadow_q[i] <= SEG_OFF;
`ifdef MUX7SEG_DIM_EN
            duty_q      <= 4'd0;
            bright_q    <= 4'hF;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            boundary_q  <= last_c;
            anodes      <= anodes_c;
            segments    <= segments_c;
            digit_idx   <= idx_q;
            frame_start <= frame_start_c;
`ifdef MUX7SEG_DIM_EN
            if (state_q == DRIVE) duty_q <= 4'(duty_c + 1'b1);
            if (boundary_q) bright_q <= brightness;
`endif
            // A load in the boundary cycle bypasses staging; otherwise pending staging is promoted
            if (boundary_q && load) begin
                for (int i = 0; i < int'(N_DIGITS); i++) shadow_q[i] <= disp_flat[7*i +: 7];
                staging_q <= disp_flat;
                pending_q <= 1'b0;
            end else if (boundary_q && pending_q) begin
                for (int i = 0; i < int'(N_DIGITS); i++) shadow_q[i] <= staging_q[7*i +: 7];
                pending_q <= 1'b0;
            end else if (load) begin
                staging_q <= disp_flat;
                pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mux_7segmt_scan.md
Name: mux_7segmt_scan

Overview:
Parametrised N-digit multiplexed 7-segment scanner that supersedes the fixed 4-digit mux.
- Time-slices one shared segment bus across N_DIGITS common anodes.
- Inserts a blanking dead-time before each digit to suppress ghosting.
- Double-buffers the digit patterns so frames never tear.
- Supports per-digit enables.
- Sits between the BCD/hex-to-7seg encoders and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 100000, clock cycles per digit slot (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 16, cycles at the start of each slot with every anode off (>= 1).
- ANODE_ACTIVE_LOW, 1, 1: an active anode drives 0; 0: an active anode drives 1.

Ports:
- Clk_signal  in  1  system clock, 100 MHz.
- Reset  in  1  synchronous, active-high reset.
- disp_flat  in  7*N_DIGITS  segment patterns, active-low; digit i is at [7i+6:7i].
- load  in  1  one-cycle strobe that requests capture of disp_flat.
- digit_en  in  N_DIGITS  per-digit enable; bit i=0 blanks digit i.
- anodes  out  N_DIGITS  anode drives; polarity set by ANODE_ACTIVE_LOW.
- segments  out  7  shared segment bus, active-low; 7'h7F means all segments off.
- digit_idx  out  clog2(N_DIGITS) (min 1)  index of the current slot.
- frame_start  out  1  one-cycle pulse in cycle 0 of the digit-0 slot.

Behaviour:
All outputs are registered. The "slot position k of digit d" is the cycle in which the outputs present position k.

Reset (synchronous, checked every cycle):
- anodes go all inactive; segments = 7'h7F; digit_idx = 0; frame_start = 0.
- Shadow and staging registers are cleared to 7'h7F; the pending flag is cleared.
- Reset has priority over everything, including mid-slot and mid-frame operation.

Start-up:
- The first cycle after Reset deasserts is slot position 0 of digit 0.
- frame_start = 1 in that cycle.

Slot counter:
- Counts 0..REFRESH_DIV-1, then wraps.
- On wrap, digit_idx increments; it wraps from N_DIGITS-1 to 0.
- Frame period = N_DIGITS*REFRESH_DIV cycles.

FSM states:
- BLANK, positions 0..BLANK_CYCLES-1: anodes all inactive; segments = 7'h7F.
- DRIVE, positions BLANK_CYCLES..REFRESH_DIV-1:
  - If digit_en[d]=1: anode d is active, all other anodes inactive, segments = shadow[d].
  - If digit_en[d]=0: behaves as BLANK. Slot timing is unchanged, so brightness stays uniform.
- Transitions: BLANK->DRIVE at position BLANK_CYCLES; DRIVE->BLANK on slot wrap.
- digit_en is sampled every cycle.

Load / double buffer:
- load=1 in a cycle captures disp_flat into staging at the next edge and sets pending.
- A repeated load while pending overwrites staging (last load wins).
- Frame boundary = last position of digit N_DIGITS-1. At that edge, if pending: shadow <= staging and pending clears.
- If load=1 exactly in the boundary cycle, shadow <= disp_flat directly (bypass) and pending clears.
- New patterns are first visible in the digit-0 slot beginning with frame_start.
- disp_flat changes without load have no effect.

At most one anode is active in any cycle. segments is 7'h7F whenever no anode is active.

Optional Feature:
MUX7SEG_DIM_EN
- Defined:
  - Adds input port brightness [3:0], sampled into a register at each frame boundary.
  - A 4-bit duty counter resets to 0 at position BLANK_CYCLES and increments each DRIVE cycle, wrapping at 16.
  - The anode is active only while duty < brightness; otherwise that cycle behaves as BLANK.
  - brightness=0: display fully dark. brightness=15: 15/16 of each 16-cycle duty period.
  - Reset value of the brightness register: 4'hF.
- Undefined: no brightness port; full-duty DRIVE as described above.

Test Plan:
Common setup: N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, ANODE_ACTIVE_LOW=1.
1. Reset held 3 cycles, then released → during reset anodes=4'b1111, segments=7'h7F; in the first cycle after release digit_idx=0 and frame_start=1.
2. load with disp_flat={7'h30,7'h24,7'h79,7'h40}, all digit_en=1; observe the next frame → per slot: 2 cycles of 4'b1111/7'h7F, then 6 cycles of each in turn:
   - digit 0: 4'b1110 / 7'h40
   - digit 1: 4'b1101 / 7'h79
   - digit 2: 4'b1011 / 7'h24
   - digit 3: 4'b0111 / 7'h30
   frame_start pulses every 32 cycles.
3. load new patterns during the digit-1 slot → digits 1..3 keep the old patterns for the rest of the frame; new patterns appear from the next frame_start. A load in the boundary cycle itself is applied at that boundary.
4. digit_en=4'b1010 → slots 0 and 2 show anodes 4'b1111 and segments 7'h7F for all 8 cycles; slots 1 and 3 are unchanged; frame period stays 32.
5. Reset asserted at position 5 of digit 2 → the next cycle shows anodes 4'b1111 and segments 7'h7F; after release, digit 0 DRIVE shows 7'h7F until a new load.
6. With MUX7SEG_DIM_EN, REFRESH_DIV=34, brightness=4 → each 32-cycle DRIVE phase has the anode active for 8 cycles (two 4-on/12-off periods); brightness=0 → anodes never active.
